// File: rtl/instr_fetch_if.sv
//==============================================================================
// Module   : instr_fetch_if
// Brief    : Instruction-memory request/response bus between the fetch stage
//            (master) and instruction memory (slave). Requests are valid/grant;
//            responses return in order with rvalid/rdata.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            o_ifetch_req;
    logic [XLEN-1:0] o_ifetch_addr;
    logic            i_ifetch_gnt;
    logic            i_ifetch_rvalid;
    logic [31:0]     i_ifetch_rdata;

    // Fetch stage side
    modport master (
        output o_ifetch_req,
        output o_ifetch_addr,
        input  i_ifetch_gnt,
        input  i_ifetch_rvalid,
        input  i_ifetch_rdata
    );

    // Instruction memory side
    modport slave (
        input  o_ifetch_req,
        input  o_ifetch_addr,
        output i_ifetch_gnt,
        output i_ifetch_rvalid,
        output i_ifetch_rdata
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
//==============================================================================
// Module   : instr_fetch
// Brief    : flintRV instruction fetch stage. Sequences the PC, issues word
//            requests (up to two outstanding), buffers responses with their PC
//            in a 2-entry FIFO and hands them to decode via valid/ready.
//            Redirects flush the FIFO and discard in-flight responses.
// Options  : FLINT_FETCH_MISALIGN_EN - flag and halt on misaligned redirects.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    instr_fetch_if.master        mem,
    input  wire logic            i_redirect,
    input  wire logic [XLEN-1:0] i_redirect_pc,
    output logic                 o_valid,
    input  wire logic            i_ready,
    output logic [31:0]          o_instr,
    output logic [XLEN-1:0]      o_pc,
    output logic                 o_misaligned
);

    localparam logic [XLEN-1:0] C_PC_STEP  = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [XLEN-1:0] C_PC_RESET = {RESET_PC[XLEN-1:2], 2'b00};

    // Program counter of the next request
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    // PCs of outstanding requests, consumed in order as responses return
    logic [XLEN-1:0] rq_pc_q [2];
    logic            rq_wr_q, rq_rd_q;
    logic [1:0]      outstanding_q, outstanding_d;
    logic [1:0]      stale_q, stale_d;

    // Output FIFO of {pc, instr}
    logic [XLEN-1:0] fifo_pc_q    [2];
    logic [31:0]     fifo_instr_q [2];
    logic            fifo_wr_q, fifo_rd_q;
    logic [1:0]      count_q, count_d;

    logic            w_halted;
    logic            w_deq;
    logic            w_credit;
    logic            w_req;
    logic            w_issue;
    logic            w_resp;
    logic            w_push;
    logic [XLEN-1:0] w_target;

    assign w_target = {i_redirect_pc[XLEN-1:2], 2'b00};

    // A head entry leaving this cycle frees its slot, which is what lets a
    // 1-cycle memory sustain one instruction per cycle without ever letting
    // outstanding + count exceed the FIFO depth.
    assign w_deq    = (count_q != 2'd0) && i_ready;
    assign w_credit = ({1'b0, outstanding_q} + {1'b0, count_q}) < (3'd2 + {2'b00, w_deq});
    assign w_req    = !i_rst && !i_redirect && !w_halted && w_credit;
    assign w_issue  = w_req && mem.i_ifetch_gnt;

    // Responses with nothing outstanding are protocol errors and are ignored
    assign w_resp   = mem.i_ifetch_rvalid && (outstanding_q != 2'd0);
    assign w_push   = w_resp && (stale_q == 2'd0) && !i_redirect;

    assign mem.o_ifetch_req  = w_req;
    assign mem.o_ifetch_addr = fetch_pc_q;

    assign o_valid = (count_q != 2'd0);
    assign o_instr = fifo_instr_q[fifo_rd_q];
    assign o_pc    = fifo_pc_q[fifo_rd_q];

    // Next-state for PC and the occupancy counters; redirect overrides all
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + {1'b0, w_issue} - {1'b0, w_resp};
        stale_d       = stale_q;
        count_d       = count_q + {1'b0, w_push} - {1'b0, w_deq};
        if (i_redirect) begin
            fetch_pc_d = w_target;
            stale_d    = outstanding_q - {1'b0, w_resp};
            count_d    = 2'd0;
        end else begin
            if (w_issue) begin
                fetch_pc_d = fetch_pc_q + C_PC_STEP;
            end
            if (w_resp && (stale_q != 2'd0)) begin
                stale_d = stale_q - 2'd1;
            end
        end
    end

    // State registers, request-PC queue and output FIFO storage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q    <= C_PC_RESET;
            outstanding_q <= 2'd0;
            stale_q       <= 2'd0;
            count_q       <= 2'd0;
            rq_wr_q       <= 1'b0;
            rq_rd_q       <= 1'b0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                rq_pc_q[k]      <= {XLEN{1'b0}};
                fifo_pc_q[k]    <= {XLEN{1'b0}};
                fifo_instr_q[k] <= 32'h0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            count_q       <= count_d;
            if (w_issue) begin
                rq_pc_q[rq_wr_q] <= fetch_pc_q;
                rq_wr_q          <= ~rq_wr_q;
            end
            if (w_resp) begin
                rq_rd_q <= ~rq_rd_q;
            end
            if (i_redirect) begin
                fifo_wr_q <= 1'b0;
                fifo_rd_q <= 1'b0;
            end else begin
                if (w_push) begin
                    fifo_pc_q[fifo_wr_q]    <= rq_pc_q[rq_rd_q];
                    fifo_instr_q[fifo_wr_q] <= mem.i_ifetch_rdata;
                    fifo_wr_q               <= ~fifo_wr_q;
                end
                if (w_deq) begin
                    fifo_rd_q <= ~fifo_rd_q;
                end
            end
        end
    end

`ifdef FLINT_FETCH_MISALIGN_EN
    logic misalign_q, misalign_d;

    // A misaligned target raises the flag and halts; an aligned one clears it
    always_comb begin
        misalign_d = misalign_q;
        if (i_redirect) begin
            misalign_d = (i_redirect_pc[1:0] != 2'b00);
        end
    end

    // Misalign/halt flag register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign w_halted     = misalign_q;
    assign o_misaligned = misalign_q;
`else
    // Target low bits are forced to zero when misalignment is not tracked
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
    assign w_halted             = 1'b0;
    assign o_misaligned         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//==============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch with an in-order memory model
//            and a scoreboard of expected {pc, instr} handed to decode.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam logic [31:0] C_RST_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b0;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_misaligned;

    instr_fetch_if #(.XLEN(32)) bus();

    instr_fetch #(
        .XLEN     (32),
        .RESET_PC (C_RST_PC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .mem           (bus),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_misaligned  (o_misaligned)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          gnt_pct  = 100;
    mem_t        mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch_pc = C_RST_PC;

    logic        s_req, s_valid, s_mis;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive memory, sample, score, then advance the models
    task automatic tick();
        logic        rv;
        logic [31:0] e;
        mem_t        m;
        rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        bus.i_ifetch_gnt    = ($urandom_range(0, 99) < gnt_pct);
        bus.i_ifetch_rvalid = rv;
        bus.i_ifetch_rdata  = rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        s_req   = bus.o_ifetch_req;
        s_addr  = bus.o_ifetch_addr;
        s_valid = o_valid;
        s_pc    = o_pc;
        s_instr = o_instr;
        s_mis   = o_misaligned;
        if (!rst) begin
            if (s_req) begin
                n_checks++;
                if (s_addr !== exp_fetch_pc) begin
                    $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, s_addr, exp_fetch_pc);
                    n_fail++;
                end
            end
            if (s_valid && ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected cyc=%0d got pc=%h exp=none", cyc, s_pc);
                    n_fail++;
                end else begin
                    e = exp_q.pop_front();
                    if (s_pc !== e || s_instr !== mem_word(e)) begin
                        $display("FAIL sb_data cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                                 cyc, s_pc, s_instr, e, mem_word(e));
                        n_fail++;
                    end
                end
            end
            n_checks++;
            if (mem_q.size() > 2) begin
                $display("FAIL outstanding cyc=%0d got=%0d exp<=2", cyc, mem_q.size());
                n_fail++;
            end
        end
        @(posedge clk);
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            exp_fetch_pc = C_RST_PC;
        end else begin
            if (rv) m = mem_q.pop_front();
            if (redirect) begin
                exp_q.delete();
                exp_fetch_pc = {redirect_pc[31:2], 2'b00};
            end else if (s_req && bus.i_ifetch_gnt) begin
                m.addr = s_addr;
                m.due  = cyc + lat;
                mem_q.push_back(m);
                exp_q.push_back(exp_fetch_pc);
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", o_valid); n_fail++; end
        n_checks++;
        if (bus.o_ifetch_req !== 1'b0) begin $display("FAIL rst_req got=%b exp=0", bus.o_ifetch_req); n_fail++; end
        n_checks++;
        if (o_misaligned !== 1'b0) begin $display("FAIL rst_mis got=%b exp=0", o_misaligned); n_fail++; end
        rst = 1'b0;
    endtask

    task automatic test_cold_start();
        lat = 1; gnt_pct = 100; ready = 1'b1;
        tick();
        n_checks++;
        if (!(s_req === 1'b1 && s_addr === C_RST_PC && s_valid === 1'b0)) begin
            $display("FAIL cold_c0 got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0", s_req, s_addr, s_valid, C_RST_PC);
            n_fail++;
        end
        tick();
        n_checks++;
        if (!(s_req === 1'b1 && s_addr === C_RST_PC + 32'd4 && s_valid === 1'b0)) begin
            $display("FAIL cold_c1 got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0", s_req, s_addr, s_valid, C_RST_PC + 32'd4);
            n_fail++;
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (!(s_valid === 1'b1 && s_pc === C_RST_PC + 32'(4 * k))) begin
                $display("FAIL cold_seq%0d got valid=%b pc=%h exp valid=1 pc=%h", k, s_valid, s_pc, C_RST_PC + 32'(4 * k));
                n_fail++;
            end
        end
    endtask

    task automatic test_ready_stall();
        ready = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        n_checks++;
        if (!(s_valid === 1'b1 && s_req === 1'b0 && exp_q.size() == 2 && mem_q.size() == 0)) begin
            $display("FAIL stall_sat got valid=%b req=%b queued=%0d inflight=%0d exp 1 0 2 0",
                     s_valid, s_req, exp_q.size(), mem_q.size());
            n_fail++;
        end
        ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_redirect_latency();
        lat = 1; ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        tick();
        redirect = 1'b0;
        tick();
        n_checks++;
        if (!(s_req === 1'b1 && s_addr === 32'h400 && s_valid === 1'b0)) begin
            $display("FAIL redir_n1 got req=%b addr=%h valid=%b exp 1 400 0", s_req, s_addr, s_valid);
            n_fail++;
        end
        tick();
        n_checks++;
        if (s_valid !== 1'b0) begin $display("FAIL redir_n2 got valid=%b exp=0", s_valid); n_fail++; end
        tick();
        n_checks++;
        if (!(s_valid === 1'b1 && s_pc === 32'h400)) begin
            $display("FAIL redir_n3 got valid=%b pc=%h exp 1 400", s_valid, s_pc);
            n_fail++;
        end
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_redirect_stale();
        int k;
        lat = 3; ready = 1'b1;
        k = 0;
        do begin tick(); k++; end while (mem_q.size() != 2 && k < 10);
        n_checks++;
        if (mem_q.size() != 2) begin $display("FAIL stale_setup got=%0d exp=2", mem_q.size()); n_fail++; end
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        k = 0;
        do begin tick(); k++; end while (!s_valid && k < 20);
        n_checks++;
        if (!(s_valid === 1'b1 && s_pc === 32'h200 && s_instr === mem_word(32'h200))) begin
            $display("FAIL stale_first got valid=%b pc=%h instr=%h exp 1 200 %h", s_valid, s_pc, s_instr, mem_word(32'h200));
            n_fail++;
        end
        for (int j = 0; j < 6; j++) tick();
        lat = 1;
        for (int j = 0; j < 4; j++) tick();
    endtask

    task automatic test_redirect_with_resp();
        int nv;
        lat = 1; ready = 1'b1;
        nv = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (s_valid) nv++; end
        n_checks++;
        if (nv != 6) begin $display("FAIL throughput got=%0d exp=6", nv); n_fail++; end
        redirect = 1'b1; redirect_pc = 32'h0000_0800;
        tick();
        redirect = 1'b0;
        tick();
        n_checks++;
        if (!(s_valid === 1'b0 && s_req === 1'b1 && s_addr === 32'h800)) begin
            $display("FAIL resp_redir got valid=%b req=%b addr=%h exp 0 1 800", s_valid, s_req, s_addr);
            n_fail++;
        end
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_wrap();
        int k;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        k = 0;
        do begin tick(); k++; end while (!s_valid && k < 20);
        n_checks++;
        if (!(s_valid === 1'b1 && s_pc === 32'hFFFF_FFFC)) begin
            $display("FAIL wrap_top got valid=%b pc=%h exp 1 fffffffc", s_valid, s_pc);
            n_fail++;
        end
        tick();
        n_checks++;
        if (!(s_valid === 1'b1 && s_pc === 32'h0)) begin
            $display("FAIL wrap_zero got valid=%b pc=%h exp 1 0", s_valid, s_pc);
            n_fail++;
        end
        for (int j = 0; j < 3; j++) tick();
    endtask

    task automatic test_misalign();
        int k;
        lat = 1; ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h0000_0202;
        tick();
        redirect = 1'b0;
`ifdef FLINT_FETCH_MISALIGN_EN
        for (int j = 0; j < 6; j++) begin
            tick();
            n_checks++;
            if (!(s_mis === 1'b1 && s_req === 1'b0 && s_valid === 1'b0)) begin
                $display("FAIL mis_halt got mis=%b req=%b valid=%b exp 1 0 0", s_mis, s_req, s_valid);
                n_fail++;
            end
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        tick();
        n_checks++;
        if (!(s_mis === 1'b0 && s_req === 1'b1 && s_addr === 32'h300)) begin
            $display("FAIL mis_clear got mis=%b req=%b addr=%h exp 0 1 300", s_mis, s_req, s_addr);
            n_fail++;
        end
        k = 0;
        do begin tick(); k++; end while (!s_valid && k < 20);
        n_checks++;
        if (!(s_valid === 1'b1 && s_pc === 32'h300)) begin
            $display("FAIL mis_resume got valid=%b pc=%h exp 1 300", s_valid, s_pc);
            n_fail++;
        end
`else
        k = 0;
        do begin tick(); k++; end while (!s_valid && k < 20);
        n_checks++;
        if (!(s_valid === 1'b1 && s_pc === 32'h200 && s_mis === 1'b0)) begin
            $display("FAIL mis_ignored got valid=%b pc=%h mis=%b exp 1 200 0", s_valid, s_pc, s_mis);
            n_fail++;
        end
`endif
        for (int j = 0; j < 4; j++) tick();
    endtask

    task automatic test_reset_midflight();
        int k;
        lat = 3; ready = 1'b0;
        for (int j = 0; j < 8; j++) tick();
        n_checks++;
        if (s_valid !== 1'b1) begin $display("FAIL mid_setup got valid=%b exp=1", s_valid); n_fail++; end
        rst = 1'b1;
        #1;
        n_checks++;
        if (!(o_valid === 1'b0 && bus.o_ifetch_req === 1'b0 && o_misaligned === 1'b0)) begin
            $display("FAIL mid_rst got valid=%b req=%b mis=%b exp 0 0 0", o_valid, bus.o_ifetch_req, o_misaligned);
            n_fail++;
        end
        tick();
        rst = 1'b0; lat = 1; ready = 1'b1;
        tick();
        n_checks++;
        if (!(s_req === 1'b1 && s_addr === C_RST_PC)) begin
            $display("FAIL mid_restart got req=%b addr=%h exp 1 %h", s_req, s_addr, C_RST_PC);
            n_fail++;
        end
        k = 0;
        do begin tick(); k++; end while (!s_valid && k < 20);
        n_checks++;
        if (!(s_valid === 1'b1 && s_pc === C_RST_PC)) begin
            $display("FAIL mid_first got valid=%b pc=%h exp 1 %h", s_valid, s_pc, C_RST_PC);
            n_fail++;
        end
        for (int j = 0; j < 4; j++) tick();
    endtask

    task automatic test_random();
        lat = 2; gnt_pct = 60;
        for (int k = 0; k < 300; k++) begin
            ready       = ($urandom_range(0, 99) < 70);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = $urandom & 32'h0000_FFFC;
            tick();
        end
        redirect = 1'b0; ready = 1'b1; gnt_pct = 100;
        for (int k = 0; k < 10; k++) tick();
    endtask

    initial begin
        bus.i_ifetch_gnt    = 1'b0;
        bus.i_ifetch_rvalid = 1'b0;
        bus.i_ifetch_rdata  = 32'h0;
        test_reset();
        test_cold_start();
        test_ready_stall();
        test_redirect_latency();
        test_redirect_stale();
        test_redirect_with_resp();
        test_wrap();
        test_misalign();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
